// File: rtl/rom_loader.sv
// Streams an image into a 64K x8 ROM over a valid/ready byte port, then
// optionally reads the image back and compares its sum against the load checksum.
module rom_loader #(
    parameter int VERIFY = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [15:0] base_address_i,
    input  logic [16:0] length_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [15:0] rom_address_o,
    output logic        rom_write_enable_o,
    output logic [7:0]  rom_data_o,
    input  logic [7:0]  rom_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [7:0]  checksum_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_VERIFY_ADDR,
        S_VERIFY_CMP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic [16:0] remaining;
    logic [15:0] base_q;
    logic [16:0] len_q;
    logic [15:0] load_addr;
    logic [7:0]  readback;

    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        s_ready_o  = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    next_state = (length_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                s_ready_o = (remaining != '0);
                accept    = s_valid_i && s_ready_o;
                if (accept && remaining == 17'd1) begin
                    next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                next_state = (VERIFY != 0) ? S_VERIFY_ADDR : S_DONE;
            end
            S_VERIFY_ADDR: begin
                next_state = S_VERIFY_CMP;
            end
            S_VERIFY_CMP: begin
                next_state = (remaining == 17'd1) ? S_DONE : S_VERIFY_ADDR;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Registered outputs and the shared load/verify byte counter
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            remaining          <= '0;
            rom_address_o      <= '0;
            rom_write_enable_o <= 1'b0;
            rom_data_o         <= '0;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            error_o            <= 1'b0;
            checksum_o         <= '0;
        end else begin
            rom_write_enable_o <= accept;
            done_o             <= (next_state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        remaining  <= length_i;
                        checksum_o <= '0;
                        error_o    <= (length_i == '0);
                        busy_o     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        rom_address_o <= load_addr;
                        rom_data_o    <= s_data_i;
                        checksum_o    <= sum8(checksum_o, s_data_i);
                        remaining     <= remaining - 17'd1;
                    end
                end
                S_FLUSH: begin
                    if (VERIFY != 0) begin
                        remaining     <= len_q;
                        rom_address_o <= base_q;
                    end
                end
                S_VERIFY_CMP: begin
                    remaining <= remaining - 17'd1;
                    if (remaining != 17'd1) begin
                        rom_address_o <= rom_address_o + 16'd1;
                    end else if (sum8(readback, rom_data_i) != checksum_o) begin
                        error_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Captured request and read-back accumulator; only meaningful after a start
    always_ff @(posedge clock_i) begin
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    base_q    <= base_address_i;
                    len_q     <= length_i;
                    load_addr <= base_address_i;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    load_addr <= load_addr + 16'd1;
                end
            end
            S_FLUSH: begin
                readback <= '0;
            end
            S_VERIFY_CMP: begin
                readback <= sum8(readback, rom_data_i);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized scoreboard bench for rom_loader: driver queues expected ROM writes
// and completion records, an independent monitor pops and compares them.
module tb_rom_loader;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] base_address_i = '0;
    logic [16:0] length_i = '0;
    logic [7:0]  s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [15:0] rom_address_o;
    logic        rom_write_enable_o;
    logic [7:0]  rom_data_o;
    logic [7:0]  rom_data_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [7:0]  checksum_o;

    rom_loader #(.VERIFY(1)) dut (
        .clock_i            (clock_i),
        .reset_i            (reset_i),
        .start_i            (start_i),
        .base_address_i     (base_address_i),
        .length_i           (length_i),
        .s_data_i           (s_data_i),
        .s_valid_i          (s_valid_i),
        .s_ready_o          (s_ready_o),
        .rom_address_o      (rom_address_o),
        .rom_write_enable_o (rom_write_enable_o),
        .rom_data_o         (rom_data_o),
        .rom_data_i         (rom_data_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .error_o            (error_o),
        .checksum_o         (checksum_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    // ROM model: 16-bit words, registered read, byte lane picked by current address bit 0
    logic [15:0] mem16 [0:32767];
    logic [15:0] rd_word = '0;
    bit          corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = '0;

    function automatic logic [15:0] rom_word_read(input logic [15:0] a);
        logic [15:0] w;
        w = mem16[a[15:1]];
        if (corrupt_en && a[15:1] == corrupt_addr[15:1]) begin
            if (corrupt_addr[0]) w[15:8] = 8'h00;
            else                 w[7:0]  = 8'h00;
        end
        return w;
    endfunction

    always @(posedge clock_i) begin
        if (rom_write_enable_o) begin
            if (rom_address_o[0]) mem16[rom_address_o[15:1]][15:8] <= rom_data_o;
            else                  mem16[rom_address_o[15:1]][7:0]  <= rom_data_o;
        end
        rd_word <= rom_word_read(rom_address_o);
    end
    assign rom_data_i = rom_address_o[0] ? rd_word[15:8] : rd_word[7:0];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  chk;
        int          cycle;
    } wr_t;

    typedef struct {
        logic       err;
        logic [7:0] chk;
        int         len;
        int         start_cyc;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];
    int    checks = 0;
    int    errors = 0;
    logic [7:0] img [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Monitor
    initial begin
        wr_t   w;
        done_t d;
        int    last_wr;
        last_wr = 0;
        forever begin
            @(negedge clock_i);
            if (!reset_i) begin
                if (!busy_o) check("ready_when_idle", 32'(s_ready_o), 32'd0);
                if (rom_write_enable_o) begin
                    if (wq.size() == 0) begin
                        bound_fail("unexpected_write");
                    end else begin
                        w = wq.pop_front();
                        check("write_addr", 32'(rom_address_o), 32'(w.addr));
                        check("write_data", 32'(rom_data_o), 32'(w.data));
                        check("write_cycle", 32'(cyc), 32'(w.cycle));
                        check("write_checksum", 32'(checksum_o), 32'(w.chk));
                        last_wr = cyc;
                    end
                end
                if (done_o) begin
                    if (dq.size() == 0) begin
                        bound_fail("unexpected_done");
                    end else begin
                        d = dq.pop_front();
                        check("done_error", 32'(error_o), 32'(d.err));
                        check("done_checksum", 32'(checksum_o), 32'(d.chk));
                        check("done_busy", 32'(busy_o), 32'd1);
                        check("done_writes_pending", 32'(wq.size()), 32'd0);
                        if (d.len == 0) check("done_latency_len0", 32'(cyc - d.start_cyc), 32'd1);
                        else            check("verify_cycles", 32'(cyc - last_wr), 32'(2 * d.len + 1));
                    end
                end
            end
        end
    end

    task automatic run_txn(input logic [15:0] base, input int len, input int mode,
                           input bit corrupt, input logic [15:0] caddr, input bit poke);
        logic [7:0]  chk;
        logic [7:0]  rb;
        logic [7:0]  run;
        logic [15:0] a;
        bit          v;
        int          idx;
        int          step;
        int          guard;
        chk = '0;
        rb  = '0;
        for (int i = 0; i < len; i++) begin
            a   = base + 16'(i);
            chk = chk + img[i];
            rb  = rb + ((corrupt && a == caddr) ? 8'h00 : img[i]);
        end
        corrupt_en   = corrupt;
        corrupt_addr = caddr;
        @(negedge clock_i);
        start_i        = 1'b1;
        base_address_i = base;
        length_i       = 17'(len);
        dq.push_back('{err: (len == 0) || (rb != chk), chk: chk, len: len, start_cyc: cyc});
        @(negedge clock_i);
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("checksum_cleared", 32'(checksum_o), 32'd0);
        check("error_on_start", 32'(error_o), 32'(len == 0));
        idx   = 0;
        step  = 0;
        guard = 0;
        run   = '0;
        while (idx < len && guard < 8 * len + 20) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (step % 5 == 0) || (step % 5 == 3) || (step % 5 == 4);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s_valid_i = v;
            s_data_i  = v ? img[idx] : 8'($urandom);
            if (poke && idx == len / 2) begin
                start_i        = 1'b1;
                base_address_i = 16'($urandom);
                length_i       = 17'($urandom_range(0, 9));
            end else begin
                start_i = 1'b0;
            end
            if (v && s_ready_o) begin
                run = run + img[idx];
                wq.push_back('{addr: base + 16'(idx), data: img[idx], chk: run, cycle: cyc + 1});
                idx++;
            end
            step++;
            guard++;
            @(negedge clock_i);
        end
        s_valid_i = 1'b0;
        start_i   = 1'b0;
        if (idx < len) bound_fail("feed_timeout");
        guard = 0;
        while (busy_o && guard < 2 * len + 20) begin
            @(negedge clock_i);
            guard++;
        end
        if (busy_o) begin
            bound_fail("busy_timeout");
            wq.delete();
            dq.delete();
        end
        corrupt_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(rom_write_enable_o), 32'd0);
        check({tag, "_ready"}, 32'(s_ready_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_error"}, 32'(error_o), 32'd0);
        check({tag, "_checksum"}, 32'(checksum_o), 32'd0);
        check({tag, "_addr"}, 32'(rom_address_o), 32'd0);
        check({tag, "_data"}, 32'(rom_data_o), 32'd0);
    endtask

    task automatic reset_midstream();
        logic [7:0] run;
        for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
        @(negedge clock_i);
        start_i        = 1'b1;
        base_address_i = 16'h2000;
        length_i       = 17'd8;
        @(negedge clock_i);
        start_i = 1'b0;
        run     = '0;
        for (int i = 0; i < 3; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = img[i];
            run       = run + img[i];
            wq.push_back('{addr: 16'h2000 + 16'(i), data: img[i], chk: run, cycle: cyc + 1});
            @(negedge clock_i);
        end
        s_data_i = img[3];
        check("we_before_reset", 32'(rom_write_enable_o), 32'd1);
        #1 reset_i = 1'b1;
        #1;
        check_all_zero("async_reset");
        check("rst_pending_writes", 32'(wq.size()), 32'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        repeat (6) @(negedge clock_i);
        check("busy_after_abort", 32'(busy_o), 32'd0);
        s_valid_i = 1'b0;
    endtask

    initial begin
        int          len;
        logic [15:0] base;
        #2 reset_i = 1'b1;
        repeat (3) @(negedge clock_i);
        check_all_zero("reset");
        reset_i = 1'b0;

        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        run_txn(16'h1000, 4, 0, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
        run_txn(16'hFFFE, 4, 0, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 5; i++) img[i] = 8'($urandom);
        run_txn(16'h3000, 5, 1, 1'b0, 16'h0000, 1'b0);

        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        run_txn(16'h1000, 4, 0, 1'b1, 16'h1002, 1'b0);

        run_txn(16'h4000, 0, 0, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 6; i++) img[i] = 8'($urandom);
        run_txn(16'h5000, 6, 2, 1'b0, 16'h0000, 1'b1);

        for (int t = 0; t < 24; t++) begin
            len  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
            base = 16'($urandom);
            for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
            run_txn(base, len, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) && len > 0,
                    base + 16'($urandom_range(0, (len > 0) ? len - 1 : 0)), 1'($urandom_range(0, 1)));
        end

        reset_midstream();

        for (int i = 0; i < 7; i++) img[i] = 8'($urandom);
        run_txn(16'hFFFD, 7, 2, 1'b0, 16'h0000, 1'b0);

        repeat (5) @(negedge clock_i);
        check("final_writes_left", 32'(wq.size()), 32'd0);
        check("final_dones_left", 32'(dq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
